// File: rtl/ula_acumulador_if.sv
// ============================================================================
// Module      : ula_acumulador_if
// Description : Operand/op/handshake bundle between the control block and the
//               accumulator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ula_acumulador_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] operand;
    logic [1:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;

    modport master (
        output operand, op, start,
        input  busy, done, acc, carry, zero
    );

    modport slave (
        input  operand, op, start,
        output busy, done, acc, carry, zero
    );
endinterface

`default_nettype wire

// File: rtl/ula_acumulador.sv
// ============================================================================
// Module      : ula_acumulador
// Description : Accumulator ALU with LOAD/ADD/SUB and iterative shift-add MUL,
//               start/busy/done handshake. Optional macro ULA_SATURATE_EN
//               turns overflow/borrow into saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_acumulador #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ula_acumulador_if.slave  ula_io
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     acc_q;
    logic                 carry_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     diff_w;
    logic                 borrow_w;
    logic [2*WIDTH-1:0]   addend_w;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     acc_d;
    logic                 carry_d;

    // Result of the current operation; MUL uses the product including this
    // cycle's partial term so the final iteration can write acc directly.
    always_comb begin
        sum_w    = {1'b0, acc_q} + {1'b0, opnd_q};
        diff_w   = acc_q - opnd_q;
        borrow_w = (opnd_q > acc_q);
        addend_w = opnd_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
        prod_d   = prod_q + addend_w;
        acc_d    = acc_q;
        carry_d  = carry_q;
        case (op_q)
            OP_LOAD: begin
                acc_d   = opnd_q;
                carry_d = 1'b0;
            end
            OP_ADD: begin
                {carry_d, acc_d} = sum_w;
`ifdef ULA_SATURATE_EN
                if (sum_w[WIDTH]) acc_d = '1;
`endif
            end
            OP_SUB: begin
                acc_d   = diff_w;
                carry_d = borrow_w;
`ifdef ULA_SATURATE_EN
                if (borrow_w) acc_d = '0;
`endif
            end
            default: begin
                acc_d   = prod_d[WIDTH-1:0];
                carry_d = |prod_d[2*WIDTH-1:WIDTH];
`ifdef ULA_SATURATE_EN
                if (carry_d) acc_d = '1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opnd_q  <= '0;
            op_q    <= OP_LOAD;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ula_io.start) begin
                        opnd_q  <= ula_io.operand;
                        op_q    <= ula_io.op;
                        mcand_q <= acc_q;
                        prod_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (ula_io.op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    if (cnt_q == LAST_IDX) begin
                        acc_q   <= acc_d;
                        carry_q <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ula_io.busy  = busy_q;
    assign ula_io.done  = done_q;
    assign ula_io.acc   = acc_q;
    assign ula_io.carry = carry_q;
    assign ula_io.zero  = (acc_q == '0);

endmodule

`default_nettype wire

// File: doc/ula_acumulador.md
Name: ula_acumulador

Overview:
- Downstream neighbour of the datapath's 4:1 operand multiplexer.
- Consumes the registered 16-bit mux output as its operand and applies one of four operations against an internal accumulator: LOAD, ADD, SUB or MUL.
- Uses a start/busy/done handshake so the control block can sequence mux selects and operations.
- MUL is multi-cycle, implemented as iterative shift-add. All other operations are single-execute-cycle.

Parameters:
- WIDTH, 16, data width of the operand and the accumulator. The MUL iteration count equals WIDTH.

Ports:
- clk  input  1  system clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- operand  input  WIDTH  operand, driven from the mux output.
- op  input  2  operation code: 00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- start  input  1  request. Sampled only in IDLE.
- busy  output  1  high while an operation executes (EXEC or MUL state).
- done  output  1  one-cycle pulse in the cycle after the accumulator is written.
- acc  output  WIDTH  accumulator register.
- carry  output  1  carry, borrow or overflow flag of the last operation.
- zero  output  1  combinational, equals (acc == 0).

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - acc = 0, carry = 0, busy = 0, done = 0; MUL counter and product cleared.
  - Reset has priority over every other event, including mid-MUL. No partial result is written.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - If start = 1 at edge E0, latch operand into opnd_r and op into op_r, capture acc as the multiplicand, and set busy = 1.
  - Next state is MUL if op = 11, otherwise EXEC.
  - start = 0 leaves the state in IDLE.
- EXEC (edge E1), result written to acc, next state DONE:
  - LOAD: acc = opnd_r, carry = 0.
  - ADD: {carry, acc} = acc + opnd_r, computed at WIDTH+1 bits.
  - SUB: acc = acc - opnd_r modulo 2^WIDTH; carry = 1 if opnd_r > acc (borrow), else 0.
- MUL:
  - Counter i runs 0..WIDTH-1. At each edge, if opnd_r[i] = 1, add (multiplicand << i) into a 2*WIDTH-bit product.
  - The edge that processes i = WIDTH-1 also writes acc = product[WIDTH-1:0] and carry = |product[2*WIDTH-1:WIDTH].
  - Next state DONE. acc is written at edge E(WIDTH).
- DONE: busy = 0, done = 1 for exactly this cycle, unconditional transition to IDLE. start is ignored here.
- start asserted while busy or done is high is ignored (not queued). operand and op changes after E0 have no effect.
- Latency from the start-sampling edge to acc valid: 1 cycle for LOAD/ADD/SUB, WIDTH cycles for MUL. done follows in the next cycle.
- Back-to-back throughput: a new start is accepted no earlier than the cycle after done.
- acc holds its value in IDLE and DONE. carry holds until the next write.

Optional Feature:
- Macro: ULA_SATURATE_EN.
- Defined:
  - ADD overflow gives acc = all ones, carry = 1.
  - SUB borrow gives acc = 0, carry = 1.
  - MUL with any nonzero upper product half gives acc = all ones, carry = 1.
  - LOAD is unchanged.
- Undefined: modular wrap as described in Behaviour. The saturation logic is absent from the netlist.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> acc = 0x0000, zero = 1, carry = 0, busy = 0, done = 0.
- LOAD 0x1234, then ADD 0xFFFF:
  - After LOAD, acc = 0x1234 and done pulses once.
  - After ADD, acc = 0x1233 and carry = 1 (saturate build: acc = 0xFFFF, carry = 1).
- LOAD 0x0005, then SUB 0x0007 -> acc = 0xFFFE, carry = 1 (saturate build: acc = 0x0000). Follow with SUB 0xFFFE -> acc = 0x0000, zero = 1, carry = 0.
- LOAD 300 (0x012C), then MUL 300:
  - busy is high for exactly 16 cycles and done pulses one cycle after acc is written.
  - Result: acc = 0x5F90, carry = 1 (saturate build: acc = 0xFFFF).
  - Repeat with LOAD 0x00FF, MUL 0x0101 -> acc = 0xFFFF, carry = 0.
- Start ignored while busy: during a MUL, pulse start with op = LOAD, operand = 0xAAAA -> ignored; the MUL result is unaffected and only one done pulse occurs.
- Reset mid-MUL: assert rst at iteration 8 -> next cycle acc = 0, busy = 0, no done pulse. A fresh LOAD 0x0001 then completes normally.
